apb_mem_ws: RTL and testbench
=============================

// Module: apb_mem_ws
// PURPOSE
//  APB4 completer memory: parametrised width/depth, programmable wait states,
//  byte strobes, per-word valid tracking. Second-generation APB memory slave;
//  sits on one PSELx of the APB interconnect as a bench/target memory.
//  Errors (range, alignment, unwritten read, partial first write) go on PSLVERR.
// PARAMETERS
//  ADDR_WIDTH   32  PADDR width (byte address)
//  DATA_WIDTH   32  PWDATA/PRDATA width; one of 8,16,32,64
//  DEPTH        32  number of DATA_WIDTH words; any value >= 1
//  WAIT_STATES  0   access-phase cycles with PREADY low before completion (0..15)
// PORTS
//  PCLK     in   1             clock, rising edge
//  PRESETn  in   1             async active-low reset
//  PSEL     in   1             completer select
//  PENABLE  in   1             access phase indicator
//  PWRITE   in   1             1 = write, 0 = read
//  PADDR    in   ADDR_WIDTH    byte address
//  PWDATA   in   DATA_WIDTH    write data
//  PSTRB    in   DATA_WIDTH/8  write byte strobes (ignored on reads)
//  PRDATA   out  DATA_WIDTH    read data
//  PREADY   out  1             transfer completes on the edge where PREADY=1
//  PSLVERR  out  1             error response; valid only while PREADY=1
// BEHAVIOUR
//  Reset (PRESETn=0, async): state=IDLE, wait counter=0, all valid bits=0.
//   Outputs go low during reset: PREADY=0, PSLVERR=0, PRDATA=0.
//   Memory array is not reset; contents are unobservable (valid=0).
//  Decode: B=DATA_WIDTH/8, AL=$clog2(B). idx=PADDR>>AL.
//   misaligned = |PADDR[AL-1:0] (only when AL>0). range_err = idx>=DEPTH.
//  FSM states IDLE, ACCESS:
//   IDLE: on edge with PSEL=1,PENABLE=0 (setup), latch PADDR, PWRITE, PWDATA,
//    PSTRB. Load cnt=WAIT_STATES. Go to ACCESS. Otherwise remain IDLE.
//   ACCESS, PSEL=1,PENABLE=1,cnt!=0: cnt<=cnt-1; stay.
//   ACCESS, PSEL=1,PENABLE=1,cnt==0: transfer completes at this edge; go IDLE.
//   ACCESS, PSEL=0: abort. Go IDLE; no memory/valid update.
//   ACCESS, PSEL=1,PENABLE=0: treated as a new setup. Relatch, reload cnt,
//    stay ACCESS; the old transfer is dropped with no side effects.
//  PREADY = (state==ACCESS && cnt==0), combinational from registers.
//   It is never high in IDLE. Zero-wait: high in the first access cycle.
//   Latency: PREADY rises WAIT_STATES cycles after access phase begins.
//  err (from latched fields, used while PREADY=1):
//   misaligned | range_err
//   | (!PWRITE && !valid[idx])
//   | (PWRITE && !valid[idx] && PSTRB!={B{1'b1}} && PSTRB!=0)
//  PSLVERR = PREADY & err. PRDATA = (PREADY && !PWRITE && !err) ? mem[idx] : 0.
//  Write at completing edge, only if !err:
//   for each byte b with PSTRB[b]=1, mem[idx][8b+:8] <= PWDATA[8b+:8].
//   Set valid[idx] if PSTRB!=0.
//   PSTRB==0 write: no change, no error.
//  Read never modifies state. Back-to-back: a setup may follow directly in the
//   cycle after completion (IDLE sees it); no idle cycle is required.
//  Reset asserted mid-ACCESS: PREADY drops immediately; pending write discarded.
//  Latched PADDR upper bits beyond idx range are covered by range_err
//   (no aliasing/wrap).
// TESTING
//  T1 reset: PRESETn=0 mid-stream -> PREADY=0,PSLVERR=0,PRDATA=0 without PCLK
//     edge; then read 0x0 -> PSLVERR=1, PRDATA=0.
//  T2 WAIT_STATES=2, write 0xDEADBEEF@0x8, PSTRB=4'hF -> PREADY low 2 access
//     cycles, high 3rd, PSLVERR=0; read 0x8 -> PRDATA=0xDEADBEEF, same latency.
//  T3 strobes: write 0x11223344@0x4 (4'hF), write 0xAABBCCDD@0x4 (4'b0010)
//     -> read 0x4 = 0x1122CC44; partial 4'b0001 write @0xC (never written)
//     -> PSLVERR=1, later read 0xC -> PSLVERR=1.
//  T4 DEPTH=32: access @0x80 -> PSLVERR=1, no write; @0x6 -> PSLVERR=1.
//     Read @0x7C after full write -> PSLVERR=0.
//  T5 abort: write @0x10 with WAIT_STATES=3, drop PSEL after 1 access cycle
//     -> read 0x10 PSLVERR=1. Back-to-back write/read @0x14 with WAIT_STATES=0
//     -> each completes in 2 cycles, read returns written data.
//  T6 reset during wait of write @0x18 -> read 0x18 after reset: PSLVERR=1.

Source files
------------

// File: rtl/apb_mem_ws.sv
// APB4 completer memory with programmable wait states, byte strobes and per-word valid tracking.
// Latency: PREADY rises WAIT_STATES cycles after the access phase begins (zero-wait completes in the first access cycle).
// Backpressure: PREADY is held low while the wait counter runs; a dropped PSEL aborts the transfer without side effects.
module apb_mem_ws #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    localparam int B  = DATA_WIDTH / 8;
    localparam int AL = $clog2(B);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((64'd1 << AL) - 64'd1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [B-1:0]          strb_q, strb_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic [IW-1:0]         idx_s;
    logic                  misaligned, range_err, valid_bit, err;
    logic                  complete, we;

    // All decode works on the latched setup fields, never on the live bus.
    always_comb begin
        idx        = addr_q >> AL;
        idx_s      = idx[IW-1:0];
        misaligned = |(addr_q & LOW_MASK);
        range_err  = (idx >= ADDR_WIDTH'(DEPTH));
        valid_bit  = range_err ? 1'b0 : valid_q[idx_s];
        err        = misaligned | range_err
                   | (!write_q && !valid_bit)
                   | (write_q && !valid_bit && (strb_q != {B{1'b1}}) && (strb_q != '0));
    end

    assign PREADY   = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
    assign PSLVERR  = PREADY && err;
    assign PRDATA   = (PREADY && !write_q && !err) ? mem_q[idx_s] : '0;
    assign complete = PREADY && PSEL && PENABLE;
    assign we       = complete && write_q && !err && (strb_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        valid_d = valid_q;
        // A setup seen in ACCESS restarts the transfer and silently drops the old one.
        if (PSEL && !PENABLE) begin
            state_d = ST_ACCESS;
            cnt_d   = 4'(WAIT_STATES);
            addr_d  = PADDR;
            write_d = PWRITE;
            wdata_d = PWDATA;
            strb_d  = PSTRB;
        end else if (state_q == ST_ACCESS) begin
            if (!PSEL) begin
                state_d = ST_IDLE;
            end else if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d = ST_IDLE;
            end
        end
        if (we) begin
            valid_d[idx_s] = 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            valid_q <= valid_d;
        end
    end

    // Array is left unreset; the valid bits hide stale contents.
    always_ff @(posedge PCLK) begin
        if (we) begin
            for (int b = 0; b < B; b++) begin
                if (strb_q[b]) begin
                    mem_q[idx_s][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_mem_ws.sv
// Bench for apb_mem_ws: three instances (2, 3 and 0 wait states) driven by a scoreboarded APB driver.
module tb_apb_mem_ws;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [31:0] paddr   [3];
    logic [31:0] pwdata  [3];
    logic [3:0]  pstrb   [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          err;
        logic [31:0] data;
        int          waits;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_mem_ws #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .DEPTH      (32),
            .WAIT_STATES((g == 0) ? 2 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .PCLK   (clk),
            .PRESETn(rst_n),
            .PSEL   (psel[g]),
            .PENABLE(penable[g]),
            .PWRITE (pwrite[g]),
            .PADDR  (paddr[g]),
            .PWDATA (pwdata[g]),
            .PSTRB  (pstrb[g]),
            .PRDATA (prdata[g]),
            .PREADY (pready[g]),
            .PSLVERR(pslverr[g])
        );
    end

    function automatic int ws_of(input int u);
        return (u == 0) ? 2 : ((u == 1) ? 3 : 0);
    endfunction

    // Called #1 after a rising edge; leaves the bus idle #1 after the completing edge.
    task automatic xfer(input int u, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input bit xerr, input logic [31:0] xrd, input string name);
        exp_t e;
        int   waits;
        exp_q.push_back('{xerr, xrd, ws_of(u), name});
        psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr;
        paddr[u] = addr; pwdata[u] = wd; pstrb[u] = strb;
        @(posedge clk); #1;
        penable[u] = 1'b1;
        @(negedge clk);
        waits = 0;
        while (pready[u] !== 1'b1 && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (pready[u] !== 1'b1 || waits != e.waits) begin
            n_bad++;
            $display("FAIL %s latency: got %0d wait cycles (pready=%b), expected %0d", e.name, waits, pready[u], e.waits);
        end
        n_cmp++;
        if (pslverr[u] !== e.err) begin
            n_bad++;
            $display("FAIL %s pslverr: got %b, expected %b", e.name, pslverr[u], e.err);
        end
        n_cmp++;
        if (prdata[u] !== e.data) begin
            n_bad++;
            $display("FAIL %s prdata: got %h, expected %h", e.name, prdata[u], e.data);
        end
        @(posedge clk); #1;
        psel[u] = 1'b0; penable[u] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        for (int u = 0; u < 3; u++) begin
            n_cmp++;
            if (pready[u] !== 1'b0 || pslverr[u] !== 1'b0 || prdata[u] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_state u%0d: got pready=%b pslverr=%b prdata=%h, expected 0/0/0", u, pready[u], pslverr[u], prdata[u]);
            end
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        xfer(2, 1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, 1'b0, 32'h0, "rst_prewrite");
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b0; paddr[2] = 32'h0;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pready[2] !== 1'b1 || prdata[2] !== 32'h5A5A5A5A) begin
            n_bad++;
            $display("FAIL rst_midread: got pready=%b prdata=%h, expected 1/5a5a5a5a", pready[2], prdata[2]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0 || prdata[2] !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_async: got pready=%b pslverr=%b prdata=%h, expected 0/0/0", pready[2], pslverr[2], prdata[2]);
        end
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);
        xfer(2, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, "rst_read_invalid");
    endtask

    task automatic test_wait_states();
        xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, "ws_write");
        idle(1);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, "ws_read");
        idle(1);
    endtask

    task automatic test_strobes();
        xfer(0, 1'b1, 32'h4, 32'h11223344, 4'hF, 1'b0, 32'h0, "strb_full");
        xfer(0, 1'b1, 32'h4, 32'hAABBCCDD, 4'b0010, 1'b0, 32'h0, "strb_byte1");
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, 32'h1122CC44, "strb_merge");
        xfer(0, 1'b1, 32'hC, 32'h99999999, 4'b0001, 1'b1, 32'h0, "strb_partial_first");
        xfer(0, 1'b0, 32'hC, 32'h0, 4'h0, 1'b1, 32'h0, "strb_partial_read");
        xfer(0, 1'b1, 32'h20, 32'h77777777, 4'h0, 1'b0, 32'h0, "strb_zero_write");
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h0, "strb_zero_read");
        idle(1);
    endtask

    task automatic test_range_align();
        xfer(2, 1'b1, 32'h7C, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, "rng_top_write");
        xfer(2, 1'b0, 32'h7C, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, "rng_top_read");
        xfer(2, 1'b1, 32'h80, 32'h12345678, 4'hF, 1'b1, 32'h0, "rng_over_write");
        xfer(2, 1'b0, 32'h80, 32'h0, 4'h0, 1'b1, 32'h0, "rng_over_read");
        xfer(2, 1'b1, 32'h4, 32'h01020304, 4'hF, 1'b0, 32'h0, "align_setup");
        xfer(2, 1'b1, 32'h6, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, "align_mis_write");
        xfer(2, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, 32'h01020304, "align_untouched");
        idle(1);
    endtask

    task automatic test_abort();
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h10; pwdata[1] = 32'h55AA55AA; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        idle(2);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'h0, "abort_read");
        idle(1);
    endtask

    task automatic test_back_to_back();
        xfer(2, 1'b1, 32'h14, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, "b2b_write");
        xfer(2, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, "b2b_read");
        xfer(2, 1'b1, 32'h14, 32'h00C0FFEE, 4'b1100, 1'b0, 32'h0, "b2b_write2");
        xfer(2, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, 32'h00C0F00D, "b2b_read2");
        idle(1);
    endtask

    task automatic test_reset_during_wait();
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h18; pwdata[0] = 32'h13579BDF; pstrb[0] = 4'hF;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        rst_n = 1'b1;
        idle(1);
        xfer(0, 1'b0, 32'h18, 32'h0, 4'h0, 1'b1, 32'h0, "rstwait_read");
        xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 32'h0, "rstwait_cleared");
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0;
            paddr[u] = '0; pwdata[u] = '0; pstrb[u] = '0;
        end
        test_reset();
        test_wait_states();
        test_strobes();
        test_range_align();
        test_abort();
        test_back_to_back();
        test_reset_during_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
